logic_unit_arbiter: RTL and testbench

- Shares one 32-bit logic unit (AND / OR / NOR / INV) between two requesters.
- Round-robin arbitration with a valid/ready handshake on each request port and a single registered response port tagged with the requester ID.
- Sits between issue logic and the bitwise datapath, so that one logic unit serves two clients.

---
 rtl/logic_arb_pkg.sv | 19 +
 rtl/logic_unit_32.sv | 33 +++
 rtl/logic_unit_arbiter.sv | 126 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_arb_pkg.sv
// Shared definitions for the two-requester logic unit arbiter: opcodes,
// FSM state encoding and default widths.
package logic_arb_pkg;

    localparam int LU_DATA_WIDTH = 32;
    localparam int LU_OP_WIDTH   = 2;

    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_NOR = 2'b10;
    localparam logic [1:0] LOP_INV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/logic_unit_32.sv
// Combinational 32-bit bitwise unit: AND / OR / NOR / INV cells feeding a
// 4:1 opcode select. No carry or overflow; INV uses operand A only.
module logic_unit_32
    import logic_arb_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0] and_y;
    logic [31:0] or_y;
    logic [31:0] nor_y;
    logic [31:0] inv_y;

    assign and_y = a & b;
    assign or_y  = a | b;
    assign nor_y = ~(a | b);
    assign inv_y = ~a;

    always_comb begin
        y = and_y;
        case (op)
            LOP_AND: y = and_y;
            LOP_OR:  y = or_y;
            LOP_NOR: y = nor_y;
            LOP_INV: y = inv_y;
            default: y = and_y;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters, with a
// registered, ID-tagged response. Define LOGIC_ARB_ZERO_FLAG_EN to add rsp_zero.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int DATA_WIDTH = LU_DATA_WIDTH,
    parameter int OP_WIDTH   = LU_OP_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    ,
    output logic                  rsp_zero
`endif
);

    arb_state_t state;
    arb_state_t state_next;

    logic rr_last;
    logic grant_any;
    logic grant_id;
    logic accept;

    logic [OP_WIDTH-1:0]   op_p0;
    logic [DATA_WIDTH-1:0] a_p0;
    logic [DATA_WIDTH-1:0] b_p0;
    logic                  id_p0;
    logic [DATA_WIDTH-1:0] lu_y;

    // On a tie the requester that did not win last time is served.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? ~rr_last : req1_valid;
    assign accept    = (state == ST_IDLE) & grant_any;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_any) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (accept) begin
            req0_ready = ~grant_id;
            req1_ready = grant_id;
        end
    end

    logic_unit_32 u_lu (
        .op (op_p0),
        .a  (a_p0),
        .b  (b_p0),
        .y  (lu_y)
    );

    // Grant stage: capture the winner's operation
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rr_last <= 1'b1;
            op_p0   <= '0;
            a_p0    <= '0;
            b_p0    <= '0;
            id_p0   <= 1'b0;
        end else if (accept) begin
            rr_last <= grant_id;
            id_p0   <= grant_id;
            op_p0   <= grant_id ? req1_op : req0_op;
            a_p0    <= grant_id ? req1_a  : req0_a;
            b_p0    <= grant_id ? req1_b  : req0_b;
        end
    end

    // Execute stage: register the result and hold it until consumed
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else if (state == ST_EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_p0;
            rsp_data  <= lu_y;
        end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef LOGIC_ARB_ZERO_FLAG_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rsp_zero <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_zero <= (lu_y == '0);
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table plus sequences for
// round-robin, backpressure and reset mid-operation; scoreboard on responses.
module tb_logic_unit_arbiter;

    logic        CLK;
    logic        RST;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic        rsp_zero;
`endif

    logic_unit_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        ,
        .rsp_zero   (rsp_zero)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [32:0] sb_q[$];
    logic        grant_q[$];
    int          rsp_cyc_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return ~a;
        endcase
    endfunction

    // Scoreboard: push on request handshake, pop on response handshake
    logic [32:0] sb_exp;
    always @(negedge CLK) begin
        if (!RST) begin
            sb_q.delete();
        end else begin
            if (req0_ready && req1_ready) chk("ready_onehot", 64'd1, 64'd0);
            if (req0_valid && req0_ready) begin
                sb_q.push_back({1'b0, model(req0_op, req0_a, req0_b)});
                grant_q.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb_q.push_back({1'b1, model(req1_op, req1_a, req1_b)});
                grant_q.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", {31'd0, rsp_id, rsp_data}, 64'd0);
                end else begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_rsp", {31'd0, rsp_id, rsp_data}, {31'd0, sb_exp});
                end
            end
        end
    end

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic issue(input vec_t v);
        if (v.id) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        @(negedge CLK);
        chk("grant_ready", {62'd0, req1_ready, req0_ready}, v.id ? 64'd2 : 64'd1);
        @(posedge CLK); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge CLK);
        chk("exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge CLK);
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_id", {63'd0, rsp_id}, {63'd0, v.id});
        chk("rsp_data", {32'd0, rsp_data}, {32'd0, v.exp_data});
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, v.exp_zero});
`endif
    endtask

    logic exp_last;
    logic g1;

    initial begin
        vecs[0] = '{1'b0, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A5FFFF, 1'b0};
        vecs[2] = '{1'b1, 2'b10, 32'hA5A5A5A5, 32'h0000FFFF, 32'h5A5A0000, 1'b0};
        vecs[3] = '{1'b1, 2'b11, 32'hA5A5A5A5, 32'h0000FFFF, 32'h5A5A5A5A, 1'b0};
        vecs[4] = '{1'b1, 2'b00, 32'hA5A5A5A5, 32'h0000FFFF, 32'h0000A5A5, 1'b0};
        vecs[5] = '{1'b0, 2'b11, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0};
        vecs[6] = '{1'b0, 2'b00, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1};
        vecs[7] = '{1'b0, 2'b01, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0};

        RST = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("reset_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        chk("reset_rsp_zero", {63'd0, rsp_zero}, 64'd0);
`endif
        @(posedge CLK); #1;
        RST = 1'b1;

        // Vector table: one request at a time, exact latency checked
        exp_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i]);
            exp_last = vecs[i].id;
        end

        // Continuous dual requests: alternating grants, one response per 3 cycles
        @(posedge CLK); #1;
        grant_q.delete();
        rsp_cyc_q.delete();
        req0_op = 2'b01; req0_a = 32'h000000F0; req0_b = 32'h0000000F;
        req1_op = 2'b10; req1_a = 32'hFFFF0000; req1_b = 32'h00000000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(posedge CLK);
        chk("rr_grant_count", 64'(grant_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++)
            chk("rr_grant_order", {63'd0, grant_q[i]}, {63'd0, (i % 2 == 0) ? ~exp_last : exp_last});
        chk("rr_rsp_count", 64'(rsp_cyc_q.size()), 64'd4);
        for (int i = 1; i < rsp_cyc_q.size(); i++)
            chk("rr_rsp_spacing", 64'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 64'd3);
        if (grant_q.size() > 0) exp_last = grant_q[grant_q.size()-1];

        // Backpressure: response held, no grants, then fair resume
        #1;
        g1 = ~exp_last;
        grant_q.delete();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_id", {63'd0, rsp_id}, {63'd0, g1});
            chk("bp_rsp_data", {32'd0, rsp_data}, g1 ? 64'h0000FFFF : 64'h000000FF);
            chk("bp_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        end
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("bp_grant_count", 64'(grant_q.size()), 64'd2);
        if (grant_q.size() == 2) begin
            chk("bp_grant_first", {63'd0, grant_q[0]}, {63'd0, g1});
            chk("bp_grant_next", {63'd0, grant_q[1]}, {63'd0, ~g1});
        end
        repeat (4) @(posedge CLK);

        // Reset while requester 0 is in EXEC: response dropped, rr_last back to 1
        #1;
        req0_op = 2'b00; req0_a = 32'hFFFFFFFF; req0_b = 32'h12345678;
        req0_valid = 1'b1;
        @(posedge CLK); #1;
        req0_valid = 1'b0;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("rst_mid_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        @(posedge CLK); #1;
        req0_op = 2'b10; req0_a = 32'h0000000F; req0_b = 32'h000000F0;
        req1_op = 2'b01; req1_a = 32'h00000001; req1_b = 32'h00000002;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge CLK);
        chk("rst_mid_first_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
        @(posedge CLK); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rst_mid_rsp_data", {32'd0, rsp_data}, 64'hFFFFFF00);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
